// File: rtl/delta_stress_monitor_pkg.sv
// Shared constants and types for the heart-rate delta/stress monitor.
// Combinational helpers only; no state, no handshake.
package delta_stress_pkg;

  localparam int DEF_WIDTH     = 6;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MARGIN    = 2;
  localparam int DEF_ALARM_LEN = 8;

  typedef logic signed [DEF_WIDTH:0] delta_t;

  // Baseline powers up at all ones so any real sample reads as "below".
  function automatic logic [31:0] baseline_rst(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/delta_stress_monitor_if.sv
// Sample input / status output bundle of the delta stress monitor.
// master drives samples and observes flags; slave is the monitor itself.
interface delta_stress_monitor_if
  import delta_stress_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                    sample_en;
  logic [WIDTH-1:0]        hart;
  logic                    gelijk;
  logic                    gestegen;
  logic                    gedaald;
  logic                    alarm;
  logic signed [WIDTH:0]   delta;

  modport master (
    output sample_en, hart,
    input  gelijk, gestegen, gedaald, alarm, delta
  );

  modport slave (
    input  sample_en, hart,
    output gelijk, gestegen, gedaald, alarm, delta
  );
endinterface

// File: rtl/delta_stress_monitor_stable_run_counter.sv
// Tracks the last accepted sample and how many consecutive repeats it has seen.
// gelijk is a register decode; gelijk_rise flags the accepting edge that completes a run.
module stable_run_counter
  import delta_stress_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             slow,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] hart,
  output logic [WIDTH-1:0] prev,
  output logic             gelijk,
  output logic             gelijk_rise
);
  localparam int              RW      = $clog2(DEPTH);
  localparam logic [RW-1:0]   RUN_MAX = RW'(DEPTH - 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]    run_q, run_d;

  always_comb begin
    prev_d = prev_q;
    run_d  = run_q;
    if (sample_en) begin
      prev_d = hart;
      if (hart == prev_q) begin
        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  assign prev        = prev_q;
  assign gelijk      = (run_q == RUN_MAX);
  assign gelijk_rise = sample_en && (run_d == RUN_MAX) && (run_q != RUN_MAX);
endmodule

// File: rtl/delta_stress_monitor.sv
// Latches a baseline after DEPTH equal samples and flags rise/fall plus a sustained-rise alarm.
// All outputs decode registers; DELTA_STRESS_HYST_EN turns rise/fall into hysteretic flags.
module delta_stress_monitor
  import delta_stress_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MARGIN    = DEF_MARGIN,
  parameter int ALARM_LEN = DEF_ALARM_LEN
) (
  input  logic                   slow,
  input  logic                   reset,
  delta_stress_monitor_if.slave  bus
);
  localparam logic [WIDTH-1:0] BASE_RST  = WIDTH'(baseline_rst(WIDTH));
  localparam int               AW        = $clog2(ALARM_LEN + 1);
  localparam logic [AW-1:0]    ALARM_MAX = AW'(ALARM_LEN);

  logic [WIDTH-1:0] prev, prev_d;
  logic [WIDTH-1:0] baseline_q, baseline_d;
  logic             gelijk, gelijk_rise;
  logic [AW-1:0]    alarm_cnt_q, alarm_cnt_d;
  logic [WIDTH:0]   prev_x, base_x;
  logic             rise_post, gest, ged;

  stable_run_counter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_run (
    .slow        (slow),
    .reset       (reset),
    .sample_en   (bus.sample_en),
    .hart        (bus.hart),
    .prev        (prev),
    .gelijk      (gelijk),
    .gelijk_rise (gelijk_rise)
  );

  // Post-update view: the alarm counter must see the flag as it will read after this edge.
  always_comb begin
    prev_d     = bus.sample_en ? bus.hart : prev;
    baseline_d = gelijk_rise ? bus.hart : baseline_q;
    prev_x     = {1'b0, prev_d};
    base_x     = {1'b0, baseline_d};
  end

`ifdef DELTA_STRESS_HYST_EN
  localparam logic [WIDTH:0] MARGIN_X = (WIDTH + 1)'(MARGIN);

  logic gestegen_q, gestegen_d, gedaald_q, gedaald_d;

  always_comb begin
    gestegen_d = gestegen_q;
    gedaald_d  = gedaald_q;
    if (bus.sample_en) begin
      if (prev_x > base_x + MARGIN_X) gestegen_d = 1'b1;
      else if (prev_x <= base_x)      gestegen_d = 1'b0;
      if (prev_x + MARGIN_X < base_x) gedaald_d  = 1'b1;
      else if (prev_x >= base_x)      gedaald_d  = 1'b0;
    end
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      gestegen_q <= 1'b0;
      gedaald_q  <= 1'b0;
    end else begin
      gestegen_q <= gestegen_d;
      gedaald_q  <= gedaald_d;
    end
  end

  assign rise_post = gestegen_d;
  assign gest      = gestegen_q;
  assign ged       = gedaald_q;
`else
  assign rise_post = (prev_x > base_x);
  assign gest      = ({1'b0, prev} > {1'b0, baseline_q});
  assign ged       = ({1'b0, prev} < {1'b0, baseline_q});
`endif

  always_comb begin
    alarm_cnt_d = alarm_cnt_q;
    if (bus.sample_en) begin
      if (rise_post) begin
        alarm_cnt_d = (alarm_cnt_q == ALARM_MAX) ? ALARM_MAX : alarm_cnt_q + 1'b1;
      end else begin
        alarm_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge slow or negedge reset) begin
    if (!reset) begin
      baseline_q  <= BASE_RST;
      alarm_cnt_q <= '0;
    end else begin
      baseline_q  <= baseline_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign bus.gelijk   = gelijk;
  assign bus.gestegen = gest;
  assign bus.gedaald  = ged;
  assign bus.alarm    = (alarm_cnt_q == ALARM_MAX);
  assign bus.delta    = $signed({1'b0, prev}) - $signed({1'b0, baseline_q});
endmodule

// File: tb/tb_delta_stress_monitor.sv
// Directed plus randomized bench for delta_stress_monitor against a sample-history model.
module tb_delta_stress_monitor;
  import delta_stress_pkg::*;

  localparam int W  = 6;
  localparam int D  = 4;
  localparam int M  = 2;
  localparam int AL = 8;

  logic slow  = 1'b0;
  logic reset = 1'b0;

  delta_stress_monitor_if #(.WIDTH(W)) bus ();

  delta_stress_monitor #(
    .WIDTH     (W),
    .DEPTH     (D),
    .MARGIN    (M),
    .ALARM_LEN (AL)
  ) dut (
    .slow  (slow),
    .reset (reset),
    .bus   (bus)
  );

  always #5 slow = ~slow;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the value sequence starts with the implicit reset value 0.
  int hist[$];
  int m_prev, m_base, m_cnt;
  bit m_gel, m_gest, m_ged;

  function automatic void update_flags();
`ifdef DELTA_STRESS_HYST_EN
    if (m_prev > m_base + M)   m_gest = 1'b1;
    else if (m_prev <= m_base) m_gest = 1'b0;
    if (m_prev + M < m_base)   m_ged  = 1'b1;
    else if (m_prev >= m_base) m_ged  = 1'b0;
`else
    m_gest = (m_prev > m_base);
    m_ged  = (m_prev < m_base);
`endif
  endfunction

  function automatic void model_reset();
    hist   = {0};
    m_prev = 0;
    m_base = (1 << W) - 1;
    m_cnt  = 0;
    m_gel  = 1'b0;
    m_gest = 1'b0;
    m_ged  = 1'b0;
`ifndef DELTA_STRESS_HYST_EN
    update_flags();
`endif
  endfunction

  function automatic void model_accept(int v);
    bit was;
    bit eq;
    was = m_gel;
    hist.push_back(v);
    if (hist.size() > D) void'(hist.pop_front());
    eq = (hist.size() == D);
    foreach (hist[i]) if (hist[i] != v) eq = 1'b0;
    m_gel  = eq;
    m_prev = v;
    if (eq && !was) m_base = v;
    update_flags();
    if (m_gest) m_cnt = (m_cnt < AL) ? m_cnt + 1 : AL;
    else        m_cnt = 0;
  endfunction

  task automatic check(string tag);
    logic signed [W:0] exp_delta;
    bit exp_alarm;
    exp_delta = (W + 1)'(m_prev - m_base);
    exp_alarm = (m_cnt == AL);
    n_tests++;
    assert (bus.gelijk === m_gel) else begin
      n_fail++;
      $error("FAIL %s gelijk got %b want %b", tag, bus.gelijk, m_gel);
    end
    n_tests++;
    assert (bus.gestegen === m_gest) else begin
      n_fail++;
      $error("FAIL %s gestegen got %b want %b", tag, bus.gestegen, m_gest);
    end
    n_tests++;
    assert (bus.gedaald === m_ged) else begin
      n_fail++;
      $error("FAIL %s gedaald got %b want %b", tag, bus.gedaald, m_ged);
    end
    n_tests++;
    assert (bus.alarm === exp_alarm) else begin
      n_fail++;
      $error("FAIL %s alarm got %b want %b", tag, bus.alarm, exp_alarm);
    end
    n_tests++;
    assert (bus.delta === exp_delta) else begin
      n_fail++;
      $error("FAIL %s delta got %0d want %0d", tag, bus.delta, exp_delta);
    end
  endtask

  task automatic step(bit en, int v, string tag);
    @(negedge slow);
    bus.sample_en = en;
    bus.hart      = W'(v);
    @(posedge slow);
    #1;
    if (en) model_accept(v);
    check(tag);
  endtask

  initial begin
    int last;
    bit en;
    bus.sample_en = 1'b0;
    bus.hart      = '0;
    model_reset();
    #12;
    check("reset");
    @(negedge slow);
    reset = 1'b1;

    // Stability run of 40 loads the baseline on the 4th edge.
    repeat (4) step(1'b1, 40, "stab40");
    step(1'b1, 45, "rise45");
    step(1'b1, 35, "fall35");
    step(1'b0, 60, "hold_a");
    step(1'b0, 12, "hold_b");

    // Re-establish baseline 40, then sustained rise with gaps between accepts.
    repeat (4) step(1'b1, 40, "restab40");
    for (int i = 0; i < AL; i++) begin
      step(1'b1, (i % 2) ? 51 : 50, "alarm_rise");
      step(1'b0, 7, "alarm_gap");
    end
    step(1'b1, 40, "alarm_clr");

    // Hysteresis walk around baseline 40.
    repeat (4) step(1'b1, 40, "hyst_base");
    step(1'b1, 42, "hyst42");
    step(1'b1, 43, "hyst43");
    step(1'b1, 41, "hyst41");
    step(1'b1, 40, "hyst40");
    step(1'b1, 38, "hyst38");
    step(1'b1, 37, "hyst37");
    step(1'b1, 39, "hyst39");

    // Asynchronous reset in the middle of a run.
    step(1'b1, 21, "pre_rst");
    repeat (3) step(1'b1, 20, "run20");
    @(negedge slow);
    bus.sample_en = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_mid");
    @(negedge slow);
    reset = 1'b1;
    repeat (3) step(1'b1, 20, "post_rst");

    // Randomized phase: repeats are frequent so baselines keep reloading.
    last = 40;
    for (int i = 0; i < 400; i++) begin
      int v;
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: v = last;
        3, 4:    v = $urandom_range(34, 46);
        default: v = $urandom_range(0, (1 << W) - 1);
      endcase
      step(en, v, "rand");
      if (en) last = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
